// File: rtl/gray_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_monitor_pkg
//  Description : Shared definitions for the Gray-code monitor slice.
//                - Default code width, shared with the upstream Gray counter.
//                - Fault cause codes reported on ErrCode.
//                - Monitor state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_monitor_pkg;

  // Code width of the upstream Gray counter; the monitor must match it.
  localparam int GRAY_WIDTH = 3;

  // Fault causes, in the order the checks are prioritised.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MULTIBIT = 2'b01,
    ERR_SEQ      = 2'b10,
    ERR_OVF      = 2'b11
  } err_code_t;

  // SYNC  : first sample after reset/resync, taken without checking.
  // TRACK : every sample is checked against the previous one.
  // FAULT : sticky; only Clear or Reset leave it.
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage : gray_monitor_pkg
`default_nettype wire

// File: rtl/gray_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_monitor_if
//  Description : Bus between the upstream Gray counter side and the monitor.
//                Ports:
//                  Gray      - Gray code from the counter
//                  En        - counter enable (same signal the counter sees)
//                  Overflow  - sticky overflow flag from the counter
//                  Binary    - registered binary decode of last good sample
//                  Valid     - Binary holds a checked sample
//                  WrapCount - saturating count of observed wraps
//                  Error     - sticky fault flag
//                  ErrCode   - fault cause
//                Modports: master drives the counter-side signals, slave is
//                the monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gray_monitor_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
);

  logic [WIDTH-1:0]  Gray;
  logic              En;
  logic              Overflow;
  logic [WIDTH-1:0]  Binary;
  logic              Valid;
  logic [WRAP_W-1:0] WrapCount;
  logic              Error;
  logic [1:0]        ErrCode;

  modport master (
    output Gray,
    output En,
    output Overflow,
    input  Binary,
    input  Valid,
    input  WrapCount,
    input  Error,
    input  ErrCode
  );

  modport slave (
    input  Gray,
    input  En,
    input  Overflow,
    output Binary,
    output Valid,
    output WrapCount,
    output Error,
    output ErrCode
  );

endinterface : gray_monitor_if
`default_nettype wire

// File: rtl/gray_monitor_gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : gray_monitor_gray2bin
//  Description : Purely combinational Gray-to-binary decoder.
//                Binary[i] is the XOR of Gray[WIDTH-1:i].
//                Ports:
//                  Gray   - Gray code in
//                  Binary - binary value out
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_monitor_gray2bin
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  wire logic [WIDTH-1:0] Gray,
  output logic      [WIDTH-1:0] Binary
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Binary[i] = ^Gray[WIDTH-1:i];
  end

endmodule : gray_monitor_gray2bin
`default_nettype wire

// File: rtl/gray_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : gray_monitor
//  Description : On-chip checker and binary-side consumer of a Gray counter.
//                Decodes each Gray sample, verifies it against the previous
//                sample and the previous enable, counts 7->0 wraps and checks
//                the first wrap against the counter's sticky Overflow flag.
//                Any violation latches a sticky fault with a cause code.
//                Ports:
//                  Clk   - rising-edge clock shared with the counter
//                  Reset - asynchronous active-low reset
//                  Clear - synchronous resync, pulsed with the counter reset
//                  bus   - gray_monitor_if slave (Gray/En/Overflow in,
//                          Binary/Valid/WrapCount/Error/ErrCode out)
//                WIDTH and WRAP_W must match the parameters of the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_monitor
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH  = GRAY_WIDTH,
  parameter int WRAP_W = 8
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  input  wire logic     Clear,
  gray_monitor_if.slave bus
);

  localparam logic [WIDTH-1:0]  c_bin_one  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] c_wrap_one = WRAP_W'(1);

  // --------------------------------------------------------------------------
  // State and history registers
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [WIDTH-1:0]  r_binary;
  logic              r_valid;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_error;
  err_code_t         r_err_code;
  logic [WIDTH-1:0]  r_prev_gray;
  logic              r_prev_en;
  logic              r_ovf_d;

  // Next-state values
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_binary_nxt;
  logic              w_valid_nxt;
  logic [WRAP_W-1:0] w_wrap_nxt;
  logic              w_error_nxt;
  err_code_t         w_err_code_nxt;
  logic              w_hist_upd;

  // --------------------------------------------------------------------------
  // Decoders: current sample and the sample taken at the previous edge
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_cur_bin;
  logic [WIDTH-1:0] w_prev_bin;

  gray_monitor_gray2bin #(.WIDTH(WIDTH)) u_dec_cur (
    .Gray   (bus.Gray),
    .Binary (w_cur_bin)
  );

  gray_monitor_gray2bin #(.WIDTH(WIDTH)) u_dec_prev (
    .Gray   (r_prev_gray),
    .Binary (w_prev_bin)
  );

  // --------------------------------------------------------------------------
  // Check terms
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_gray_diff;
  logic             w_multibit;
  logic [WIDTH-1:0] w_exp_bin;
  logic             w_seq_bad;
  logic             w_wrap;
  logic             w_first_wrap;
  logic             w_ovf_rise;
  logic             w_ovf_fall;
  logic             w_ovf_bad;
  logic             w_wrap_sat;

  assign w_gray_diff = bus.Gray ^ r_prev_gray;
  // Clearing the lowest set bit leaves something only when two or more bits
  // changed.
  assign w_multibit  = |(w_gray_diff & (w_gray_diff - c_bin_one));

  // The counter advanced at the previous edge exactly when En was high there.
  assign w_exp_bin   = r_prev_en ? (w_prev_bin + c_bin_one) : w_prev_bin;
  assign w_seq_bad   = (w_cur_bin != w_exp_bin);

  assign w_wrap       = r_prev_en & (&w_prev_bin);
  // Only the first wrap since resync may (and must) raise the sticky flag.
  assign w_first_wrap = w_wrap & (r_wrap_cnt == '0);
  assign w_ovf_rise   = bus.Overflow & ~r_ovf_d;
  assign w_ovf_fall   = r_ovf_d & ~bus.Overflow;
  // A rise without a first wrap, a first wrap without a rise, or any fall.
  assign w_ovf_bad    = (w_ovf_rise ^ w_first_wrap) | w_ovf_fall;

  assign w_wrap_sat   = &r_wrap_cnt;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_binary_nxt   = r_binary;
    w_valid_nxt    = r_valid;
    w_wrap_nxt     = r_wrap_cnt;
    w_error_nxt    = r_error;
    w_err_code_nxt = r_err_code;
    w_hist_upd     = 1'b0;

    case (r_state)
      ST_SYNC: begin
        w_binary_nxt = w_cur_bin;
        w_valid_nxt  = 1'b1;
        w_hist_upd   = 1'b1;
        w_state_nxt  = ST_TRACK;
      end

      ST_TRACK: begin
        w_hist_upd = 1'b1;
        if (w_multibit || w_seq_bad || w_ovf_bad) begin
          // Binary keeps the last good value; the offending sample is dropped.
          w_state_nxt = ST_FAULT;
          w_error_nxt = 1'b1;
          if (w_multibit) begin
            w_err_code_nxt = ERR_MULTIBIT;
          end else if (w_seq_bad) begin
            w_err_code_nxt = ERR_SEQ;
          end else begin
            w_err_code_nxt = ERR_OVF;
          end
        end else begin
          w_binary_nxt = w_cur_bin;
          if (w_wrap && !w_wrap_sat) begin
            w_wrap_nxt = r_wrap_cnt + c_wrap_one;
          end
        end
      end

      ST_FAULT: begin
        // Everything frozen until Clear or Reset.
      end

      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_SYNC;
      r_binary    <= '0;
      r_valid     <= 1'b0;
      r_wrap_cnt  <= '0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_prev_gray <= '0;
      r_prev_en   <= 1'b0;
      r_ovf_d     <= 1'b0;
    end else if (Clear) begin
      // Resync discards all history, matching the counter's own reset.
      r_state     <= ST_SYNC;
      r_binary    <= '0;
      r_valid     <= 1'b0;
      r_wrap_cnt  <= '0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_prev_gray <= '0;
      r_prev_en   <= 1'b0;
      r_ovf_d     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_binary   <= w_binary_nxt;
      r_valid    <= w_valid_nxt;
      r_wrap_cnt <= w_wrap_nxt;
      r_error    <= w_error_nxt;
      r_err_code <= w_err_code_nxt;
      if (w_hist_upd) begin
        r_prev_gray <= bus.Gray;
        r_prev_en   <= bus.En;
        r_ovf_d     <= bus.Overflow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.Binary    = r_binary;
  assign bus.Valid     = r_valid;
  assign bus.WrapCount = r_wrap_cnt;
  assign bus.Error     = r_error;
  assign bus.ErrCode   = r_err_code;

endmodule : gray_monitor
`default_nettype wire

// File: tb/tb_gray_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_monitor
//  Description : Self-checking bench for gray_monitor. Models the upstream
//                Gray counter and the monitor's rules at a behavioural level,
//                compares every output on every falling edge, and pins the
//                model with hand-computed directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_monitor;
  import gray_monitor_pkg::*;

  localparam int W        = 3;
  localparam int WW       = 2;
  localparam int MAXV     = (1 << W) - 1;
  localparam int WRAP_MAX = (1 << WW) - 1;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  logic Clear = 1'b0;

  gray_monitor_if #(.WIDTH(W), .WRAP_W(WW)) bus ();

  gray_monitor #(.WIDTH(W), .WRAP_W(WW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Upstream counter model
  int cnt = 0;
  int ovf = 0;

  // Monitor model
  int m_bin = 0, m_valid = 0, m_wraps = 0, m_err = 0, m_code = 0;
  bit m_synced = 0, m_faulted = 0;
  int h_gray = 0, h_en = 0, h_ovf = 0;
  bit cmp_on = 0;

  function automatic int g_of(input int b);
    return (b ^ (b >> 1)) & MAXV;
  endfunction

  function automatic int dec(input int g);
    int b = 0;
    for (int i = 0; i < W; i++) b |= ($countones(g >> i) & 1) << i;
    return b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bin = 0; m_valid = 0; m_wraps = 0; m_err = 0; m_code = 0;
    m_synced = 0; m_faulted = 0;
    h_gray = 0; h_en = 0; h_ovf = 0;
  endtask

  // Behavioural model of the monitor, stepped on each clock edge.
  always @(posedge Clk or negedge Reset) begin : mdl
    int g, e, o, code, pb;
    bit first, rise, fall;
    if (!Reset || Clear) begin
      model_reset();
    end else if (!m_faulted) begin
      g = int'(bus.Gray); e = int'(bus.En); o = int'(bus.Overflow);
      if (!m_synced) begin
        m_bin = dec(g); m_valid = 1; m_synced = 1;
      end else begin
        pb    = dec(h_gray);
        first = (h_en == 1) && (pb == MAXV) && (m_wraps == 0);
        rise  = (o == 1) && (h_ovf == 0);
        fall  = (o == 0) && (h_ovf == 1);
        code  = 0;
        if ($countones(g ^ h_gray) > 1)              code = 1;
        else if (dec(g) != ((pb + h_en) % (MAXV + 1))) code = 2;
        else if ((rise != first) || fall)              code = 3;
        if (code != 0) begin
          m_faulted = 1; m_err = 1; m_code = code;
        end else begin
          m_bin = dec(g);
          if (h_en == 1 && pb == MAXV && m_wraps < WRAP_MAX) m_wraps++;
        end
      end
      h_gray = g; h_en = e; h_ovf = o;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (cmp_on) begin
      check("binary",    int'(bus.Binary),    m_bin);
      check("valid",     int'(bus.Valid),     m_valid);
      check("wrapcount", int'(bus.WrapCount), m_wraps);
      check("error",     int'(bus.Error),     m_err);
      check("errcode",   int'(bus.ErrCode),   m_code);
    end
  end

  // One cycle: present the counter's output (optionally corrupted), then let
  // the counter advance at the edge.
  task automatic drive(input bit en, input bit clr, input int gmask, input int oforce);
    bus.En       = en;
    Clear        = clr;
    bus.Gray     = W'(g_of(cnt) ^ gmask);
    bus.Overflow = (oforce < 0) ? ovf[0] : oforce[0];
    @(posedge Clk);
    if (clr) begin
      cnt = 0; ovf = 0;
    end else if (en) begin
      if (cnt == MAXV) ovf = 1;
      cnt = (cnt + 1) % (MAXV + 1);
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, -1);
  endtask

  initial begin
    bus.Gray = '0; bus.En = 1'b0; bus.Overflow = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_binary", int'(bus.Binary), 0);
    check("rst_valid",  int'(bus.Valid), 0);
    check("rst_wrap",   int'(bus.WrapCount), 0);
    check("rst_error",  int'(bus.Error), 0);
    check("rst_code",   int'(bus.ErrCode), int'(ERR_NONE));
    Reset  = 1'b1;
    cmp_on = 1'b1;

    // Full counting sequence with one wrap.
    drive(1'b0, 1'b1, 0, -1);
    check("clr_valid", int'(bus.Valid), 0);
    run(10);
    check("seq_binary", int'(bus.Binary), 1);
    check("seq_wrap",   int'(bus.WrapCount), 1);
    check("seq_error",  int'(bus.Error), 0);
    check("mdl_wraps",  m_wraps, 1);

    // Enable toggling: Binary holds while En is low.
    drive(1'b1, 1'b0, 0, -1);
    drive(1'b0, 1'b0, 0, -1);
    drive(1'b0, 1'b0, 0, -1);
    check("hold_binary", int'(bus.Binary), 3);
    drive(1'b1, 1'b0, 0, -1);
    drive(1'b1, 1'b0, 0, -1);
    check("hold_binary2", int'(bus.Binary), 4);
    check("hold_error",   int'(bus.Error), 0);

    // Multi-bit change: 001 -> 010.
    drive(1'b0, 1'b1, 0, -1);
    run(2);
    drive(1'b1, 1'b0, 1, -1);
    check("mb_error",  int'(bus.Error), 1);
    check("mb_code",   int'(bus.ErrCode), int'(ERR_MULTIBIT));
    check("mb_binary", int'(bus.Binary), 1);
    check("mdl_code",  m_code, 1);
    drive(1'b1, 1'b0, 0, -1);
    check("mb_frozen", int'(bus.Binary), 1);

    // Clear after fault, then wrong sequence: 011 held (En=0) -> 010.
    drive(1'b0, 1'b1, 0, -1);
    check("clr_error",  int'(bus.Error), 0);
    check("clr_valid2", int'(bus.Valid), 0);
    drive(1'b1, 1'b0, 0, -1);
    check("resync_valid", int'(bus.Valid), 1);
    drive(1'b1, 1'b0, 0, -1);
    drive(1'b0, 1'b0, 0, -1);
    drive(1'b0, 1'b0, 1, -1);
    check("seq_code", int'(bus.ErrCode), int'(ERR_SEQ));

    // Overflow raised on 010 -> 110.
    drive(1'b0, 1'b1, 0, -1);
    run(4);
    drive(1'b1, 1'b0, 0, 1);
    check("ovf_code1", int'(bus.ErrCode), int'(ERR_OVF));

    // Wrap 100 -> 000 with Overflow held low.
    drive(1'b0, 1'b1, 0, -1);
    run(8);
    drive(1'b1, 1'b0, 0, 0);
    check("ovf_code2", int'(bus.ErrCode), int'(ERR_OVF));

    // Wrap followed by En low is legal.
    drive(1'b0, 1'b1, 0, -1);
    run(8);
    drive(1'b0, 1'b0, 0, -1);
    drive(1'b0, 1'b0, 0, -1);
    check("wrap_idle_err",  int'(bus.Error), 0);
    check("wrap_idle_wrap", int'(bus.WrapCount), 1);

    // Saturation: five wraps, then more wraps with Overflow already high.
    drive(1'b0, 1'b1, 0, -1);
    run(48);
    check("sat_wrap",  int'(bus.WrapCount), WRAP_MAX);
    check("sat_error", int'(bus.Error), 0);
    run(16);
    check("sat_wrap2",  int'(bus.WrapCount), WRAP_MAX);
    check("sat_error2", int'(bus.Error), 0);

    // Asynchronous reset between edges.
    #2 Reset = 1'b0;
    #1;
    check("arst_binary", int'(bus.Binary), 0);
    check("arst_valid",  int'(bus.Valid), 0);
    check("arst_wrap",   int'(bus.WrapCount), 0);
    check("arst_error",  int'(bus.Error), 0);
    @(posedge Clk);
    #2 Reset = 1'b1;
    cnt = 0; ovf = 0;

    // Randomised run with occasional corruption and resyncs.
    for (int i = 0; i < 3000; i++) begin
      bit en, clr;
      int gm, of;
      en  = ($urandom_range(0, 3) != 0);
      gm  = ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, MAXV)) : 0;
      of  = ($urandom_range(0, 59) == 0) ? (ovf ^ 1) : -1;
      clr = m_faulted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      drive(en, clr, gm, of);
    end

    @(posedge Clk);
    #1;
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gray_monitor
`default_nettype wire
